// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage: widths, RAM access size codes,
// write-back source codes, FSM state type and an alignment helper.
package lsu_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ARGS_WIDTH = 3;
  localparam int GPRS_WIDTH = 5;

  // RAM access size / extension codes
  localparam logic [ARGS_WIDTH-1:0] RAM_BYT_1U = 3'd0;
  localparam logic [ARGS_WIDTH-1:0] RAM_BYT_1S = 3'd1;
  localparam logic [ARGS_WIDTH-1:0] RAM_BYT_2U = 3'd2;
  localparam logic [ARGS_WIDTH-1:0] RAM_BYT_2S = 3'd3;
  localparam logic [ARGS_WIDTH-1:0] RAM_BYT_4  = 3'd4;

  // Write-back source codes; MEM marks a load
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_ALU = 3'd0;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_MEM = 3'd1;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_PC  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; unknown sizes act as words.
  function automatic logic is_misaligned(input logic [ARGS_WIDTH-1:0] byt,
                                         input logic [1:0] addr_lo);
    case (byt)
      RAM_BYT_1U, RAM_BYT_1S: return 1'b0;
      RAM_BYT_2U, RAM_BYT_2S: return addr_lo[0];
      default:                return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic for the load/store stage (purely combinational):
// builds store strobes and lane-replicated store data, and selects and
// extends the addressed lane of a loaded word. Unknown size codes act as words.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [ARGS_WIDTH-1:0] byt,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [DATA_WIDTH-1:0] ld_word,
  output logic [3:0]            wr_mask,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane selection by address, then strobe/replication/extension by size
  always_comb begin
    ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
    ld_half = ld_word[{addr_lo[1], 4'b0000} +: 16];
    wr_mask = 4'hF;
    wr_data = st_data;
    ld_data = ld_word;
    case (byt)
      RAM_BYT_1U, RAM_BYT_1S: begin
        wr_mask = 4'b0001 << addr_lo;
        wr_data = {4{st_data[7:0]}};
        ld_data = {{24{(byt == RAM_BYT_1S) & ld_byte[7]}}, ld_byte};
      end
      RAM_BYT_2U, RAM_BYT_2S: begin
        wr_mask = 4'b0011 << {addr_lo[1], 1'b0};
        wr_data = {2{st_data[15:0]}};
        ld_data = {{16{(byt == RAM_BYT_2S) & ld_half[15]}}, ld_half};
      end
      default: begin
        wr_mask = 4'hF;
        wr_data = st_data;
        ld_data = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage between exu and wbu. Captures one exu result per
// transaction, issues at most one data-RAM request (req/ack with timeout),
// and holds the result until wbu takes it.
// Optional feature macro: LSU_MISALIGN_CHK_EN (misaligned half/word accesses
// skip the RAM and report o_lsu_misalign).
//
// Handshakes: exu->lsu transfers on i_e2l_valid & o_lsu_ready (ready only in
// IDLE); lsu->wbu transfers on o_lsu_valid & i_l2w_ready and outputs stay
// stable while valid is waiting; RAM request completes on the cycle i_ram_ack
// is high while o_ram_req is high, with i_ram_rd_data valid that cycle.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_e2l_valid,
  output logic                  o_lsu_ready,
  output logic                  o_lsu_valid,
  input  logic                  i_l2w_ready,
  input  logic [ADDR_WIDTH-1:0] i_e2l_pc,
  input  logic                  i_e2l_ctr_reg_wr_en,
  input  logic [ARGS_WIDTH-1:0] i_e2l_ctr_reg_wr_src,
  input  logic [GPRS_WIDTH-1:0] i_e2l_gpr_rd_id,
  input  logic [ARGS_WIDTH-1:0] i_e2l_ctr_ram_byt,
  input  logic                  i_e2l_ctr_ram_wr_en,
  input  logic [DATA_WIDTH-1:0] i_e2l_res,
  input  logic [DATA_WIDTH-1:0] i_e2l_rs2_data,
  output logic                  o_ram_req,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [3:0]            o_ram_wr_mask,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  input  logic                  i_ram_ack,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic [ADDR_WIDTH-1:0] o_lsu_pc,
  output logic                  o_lsu_ctr_reg_wr_en,
  output logic [ARGS_WIDTH-1:0] o_lsu_ctr_reg_wr_src,
  output logic [GPRS_WIDTH-1:0] o_lsu_gpr_rd_id,
  output logic [DATA_WIDTH-1:0] o_lsu_alu_res,
  output logic [DATA_WIDTH-1:0] o_lsu_ram_res,
  output logic                  o_lsu_err,
`ifdef LSU_MISALIGN_CHK_EN
  output logic                  o_lsu_misalign,
`endif
  output lsu_state_t            o_dbg_state
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  lsu_state_t state_q, state_d;
  logic [7:0] cnt_q;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  reg_wr_en_q;
  logic [ARGS_WIDTH-1:0] reg_wr_src_q;
  logic [GPRS_WIDTH-1:0] rd_id_q;
  logic [ARGS_WIDTH-1:0] ram_byt_q;
  logic                  ram_wr_en_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] ram_res_q;
  logic                  err_q;

  logic                  is_mem_in;
  logic                  misalign_in;
  logic                  cnt_hit;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] lane_wr_data;
  logic [DATA_WIDTH-1:0] lane_ld_data;

  assign is_mem_in = i_e2l_ctr_ram_wr_en || (i_e2l_ctr_reg_wr_src == REG_WR_SRC_MEM);
  // The request that is about to end its TMO-th cycle without an ack times out.
  assign cnt_hit   = ((cnt_q + 8'd1) == TMO);

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign_q;
  assign misalign_in    = is_mem_in && is_misaligned(i_e2l_ctr_ram_byt, i_e2l_res[1:0]);
  assign o_lsu_misalign = misalign_q;
`else
  assign misalign_in = 1'b0;
`endif

  lsu_lane u_lane (
    .byt     (ram_byt_q),
    .addr_lo (res_q[1:0]),
    .st_data (rs2_q),
    .ld_word (i_ram_rd_data),
    .wr_mask (lane_mask),
    .wr_data (lane_wr_data),
    .ld_data (lane_ld_data)
  );

  // State register
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    o_lsu_ready = 1'b0;
    o_lsu_valid = 1'b0;
    o_ram_req   = 1'b0;
    case (state_q)
      IDLE: begin
        o_lsu_ready = 1'b1;
        if (i_e2l_valid) state_d = (is_mem_in && !misalign_in) ? REQ : DONE;
      end
      REQ: begin
        o_ram_req = 1'b1;
        if (i_ram_ack || cnt_hit) state_d = DONE;
      end
      DONE: begin
        o_lsu_valid = 1'b1;
        if (i_l2w_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request-cycle counter: counts while staying in REQ, cleared otherwise
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)                              cnt_q <= 8'd0;
    else if (state_q == REQ && state_d == REQ)     cnt_q <= cnt_q + 8'd1;
    else                                           cnt_q <= 8'd0;
  end

  // Transaction capture, load-data latch and error flags
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      pc_q         <= '0;
      reg_wr_en_q  <= 1'b0;
      reg_wr_src_q <= '0;
      rd_id_q      <= '0;
      ram_byt_q    <= '0;
      ram_wr_en_q  <= 1'b0;
      res_q        <= '0;
      rs2_q        <= '0;
      ram_res_q    <= '0;
      err_q        <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else if (state_q == IDLE && i_e2l_valid) begin
      pc_q         <= i_e2l_pc;
      reg_wr_en_q  <= i_e2l_ctr_reg_wr_en && !misalign_in;
      reg_wr_src_q <= i_e2l_ctr_reg_wr_src;
      rd_id_q      <= i_e2l_gpr_rd_id;
      ram_byt_q    <= i_e2l_ctr_ram_byt;
      ram_wr_en_q  <= i_e2l_ctr_ram_wr_en;
      res_q        <= i_e2l_res;
      rs2_q        <= i_e2l_rs2_data;
      ram_res_q    <= '0;
      err_q        <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      misalign_q   <= misalign_in;
`endif
    end else if (state_q == REQ) begin
      // An ack on the timeout cycle still completes the access normally.
      if (i_ram_ack) begin
        if (!ram_wr_en_q) ram_res_q <= lane_ld_data;
      end else if (cnt_hit) begin
        err_q       <= 1'b1;
        reg_wr_en_q <= 1'b0;
      end
    end
  end

  assign o_ram_wr_en   = o_ram_req && ram_wr_en_q;
  assign o_ram_addr    = o_ram_req ? {res_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign o_ram_wr_mask = o_ram_wr_en ? lane_mask : 4'h0;
  assign o_ram_wr_data = o_ram_wr_en ? lane_wr_data : '0;

  assign o_lsu_pc             = pc_q;
  assign o_lsu_ctr_reg_wr_en  = reg_wr_en_q;
  assign o_lsu_ctr_reg_wr_src = reg_wr_src_q;
  assign o_lsu_gpr_rd_id      = rd_id_q;
  assign o_lsu_alu_res        = res_q;
  assign o_lsu_ram_res        = ram_res_q;
  assign o_lsu_err            = err_q;
  assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized
// transactions checked against a size/offset arithmetic reference model.
module tb_lsu;
  import lsu_pkg::*;

  logic                  i_sys_clk;
  logic                  i_sys_rst_n;
  logic                  i_e2l_valid;
  logic                  o_lsu_ready;
  logic                  o_lsu_valid;
  logic                  i_l2w_ready;
  logic [ADDR_WIDTH-1:0] i_e2l_pc;
  logic                  i_e2l_ctr_reg_wr_en;
  logic [ARGS_WIDTH-1:0] i_e2l_ctr_reg_wr_src;
  logic [GPRS_WIDTH-1:0] i_e2l_gpr_rd_id;
  logic [ARGS_WIDTH-1:0] i_e2l_ctr_ram_byt;
  logic                  i_e2l_ctr_ram_wr_en;
  logic [DATA_WIDTH-1:0] i_e2l_res;
  logic [DATA_WIDTH-1:0] i_e2l_rs2_data;
  logic                  o_ram_req;
  logic                  o_ram_wr_en;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [3:0]            o_ram_wr_mask;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic                  i_ram_ack;
  logic [DATA_WIDTH-1:0] i_ram_rd_data;
  logic [ADDR_WIDTH-1:0] o_lsu_pc;
  logic                  o_lsu_ctr_reg_wr_en;
  logic [ARGS_WIDTH-1:0] o_lsu_ctr_reg_wr_src;
  logic [GPRS_WIDTH-1:0] o_lsu_gpr_rd_id;
  logic [DATA_WIDTH-1:0] o_lsu_alu_res;
  logic [DATA_WIDTH-1:0] o_lsu_ram_res;
  logic                  o_lsu_err;
`ifdef LSU_MISALIGN_CHK_EN
  logic                  o_lsu_misalign;
`endif
  lsu_state_t            o_dbg_state;

  int total = 0;
  int bad   = 0;

  // observations recorded by the driver
  int          obs_lat;
  int          obs_req_cnt;
  logic        obs_unstable;
  logic        obs_wr_en;
  logic [31:0] obs_addr;
  logic [3:0]  obs_mask;
  logic [31:0] obs_wdata;

  logic [31:0] exp_q[$];

  lsu dut (
    .i_sys_clk            (i_sys_clk),
    .i_sys_rst_n          (i_sys_rst_n),
    .i_e2l_valid          (i_e2l_valid),
    .o_lsu_ready          (o_lsu_ready),
    .o_lsu_valid          (o_lsu_valid),
    .i_l2w_ready          (i_l2w_ready),
    .i_e2l_pc             (i_e2l_pc),
    .i_e2l_ctr_reg_wr_en  (i_e2l_ctr_reg_wr_en),
    .i_e2l_ctr_reg_wr_src (i_e2l_ctr_reg_wr_src),
    .i_e2l_gpr_rd_id      (i_e2l_gpr_rd_id),
    .i_e2l_ctr_ram_byt    (i_e2l_ctr_ram_byt),
    .i_e2l_ctr_ram_wr_en  (i_e2l_ctr_ram_wr_en),
    .i_e2l_res            (i_e2l_res),
    .i_e2l_rs2_data       (i_e2l_rs2_data),
    .o_ram_req            (o_ram_req),
    .o_ram_wr_en          (o_ram_wr_en),
    .o_ram_addr           (o_ram_addr),
    .o_ram_wr_mask        (o_ram_wr_mask),
    .o_ram_wr_data        (o_ram_wr_data),
    .i_ram_ack            (i_ram_ack),
    .i_ram_rd_data        (i_ram_rd_data),
    .o_lsu_pc             (o_lsu_pc),
    .o_lsu_ctr_reg_wr_en  (o_lsu_ctr_reg_wr_en),
    .o_lsu_ctr_reg_wr_src (o_lsu_ctr_reg_wr_src),
    .o_lsu_gpr_rd_id      (o_lsu_gpr_rd_id),
    .o_lsu_alu_res        (o_lsu_alu_res),
    .o_lsu_ram_res        (o_lsu_ram_res),
    .o_lsu_err            (o_lsu_err),
`ifdef LSU_MISALIGN_CHK_EN
    .o_lsu_misalign       (o_lsu_misalign),
`endif
    .o_dbg_state          (o_dbg_state)
  );

  // clock / reset
  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [2:0] byt);
    if (byt == RAM_BYT_1U || byt == RAM_BYT_1S) return 1;
    if (byt == RAM_BYT_2U || byt == RAM_BYT_2S) return 2;
    return 4;
  endfunction

  function automatic int off_of(input logic [2:0] byt, input logic [31:0] addr);
    int sz = sz_of(byt);
    int a  = int'(addr[1:0]);
    return (a / sz) * sz;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] byt, input logic [31:0] addr);
    int sz = sz_of(byt);
    return 4'(((1 << sz) - 1) << off_of(byt, addr));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] byt, input logic [31:0] d);
    int sz = sz_of(byt);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] byt, input logic [31:0] addr,
                                             input logic [31:0] word);
    int     sz   = sz_of(byt);
    longint full = longint'(1) << (8 * sz);
    longint val  = (longint'(word) >> (8 * off_of(byt, addr))) & (full - 1);
    if ((byt == RAM_BYT_1S || byt == RAM_BYT_2S) && val >= (full / 2)) val = val - full;
    return 32'(val);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_e2l_valid = 0; i_l2w_ready = 0; i_ram_ack = 0; i_ram_rd_data = '0;
    i_e2l_pc = '0; i_e2l_ctr_reg_wr_en = 0; i_e2l_ctr_reg_wr_src = '0;
    i_e2l_gpr_rd_id = '0; i_e2l_ctr_ram_byt = '0; i_e2l_ctr_ram_wr_en = 0;
    i_e2l_res = '0; i_e2l_rs2_data = '0;
  endtask

  // Issues one transaction at a negedge and runs it until o_lsu_valid (bounded),
  // answering the RAM after ack_delay request cycles.
  task automatic do_txn(input logic [31:0] pc, input logic reg_wr, input logic [2:0] src,
                        input logic [4:0] rd, input logic [2:0] byt, input logic ram_wr,
                        input logic [31:0] res, input logic [31:0] rs2,
                        input int ack_delay, input logic [31:0] rd_word);
    i_e2l_valid = 1; i_e2l_pc = pc; i_e2l_ctr_reg_wr_en = reg_wr;
    i_e2l_ctr_reg_wr_src = src; i_e2l_gpr_rd_id = rd; i_e2l_ctr_ram_byt = byt;
    i_e2l_ctr_ram_wr_en = ram_wr; i_e2l_res = res; i_e2l_rs2_data = rs2;
    @(negedge i_sys_clk);
    i_e2l_valid = 0; i_e2l_res = $urandom(); i_e2l_rs2_data = $urandom();
    obs_lat = 0; obs_req_cnt = 0; obs_unstable = 0;
    obs_addr = '0; obs_mask = '0; obs_wdata = '0; obs_wr_en = 0;
    while (o_lsu_valid !== 1'b1 && obs_lat < 400) begin
      if (o_ram_req === 1'b1) begin
        if (obs_req_cnt == 0) begin
          obs_addr = o_ram_addr; obs_mask = o_ram_wr_mask;
          obs_wdata = o_ram_wr_data; obs_wr_en = o_ram_wr_en;
        end else if (o_ram_addr !== obs_addr || o_ram_wr_mask !== obs_mask ||
                     o_ram_wr_data !== obs_wdata || o_ram_wr_en !== obs_wr_en) begin
          obs_unstable = 1;
        end
        if (obs_req_cnt == ack_delay) begin
          i_ram_ack = 1; i_ram_rd_data = rd_word;
        end
        obs_req_cnt++;
      end
      @(negedge i_sys_clk);
      i_ram_ack = 0; i_ram_rd_data = $urandom();
      obs_lat++;
    end
  endtask

  task automatic accept(input int wait_cycles);
    repeat (wait_cycles) @(negedge i_sys_clk);
    i_l2w_ready = 1;
    @(negedge i_sys_clk);
    i_l2w_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if (o_lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_lsu_ready); end
    total++; if (o_lsu_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_lsu_valid); end
    total++; if (o_ram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", o_ram_req); end
    total++; if (o_dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, IDLE); end
    total++;
    if ({o_lsu_alu_res, o_lsu_ram_res, o_lsu_pc, o_lsu_err, o_lsu_ctr_reg_wr_en, o_ram_wr_mask} !== '0) begin
      bad++; $display("FAIL reset_outputs got alu=%h ram=%h pc=%h err=%b wen=%b mask=%h exp all 0",
                      o_lsu_alu_res, o_lsu_ram_res, o_lsu_pc, o_lsu_err, o_lsu_ctr_reg_wr_en, o_ram_wr_mask);
    end
  endtask

  task automatic test_nonmem();
    do_txn(32'h400, 1, REG_WR_SRC_ALU, 5'd7, RAM_BYT_4, 0, 32'h1234, 32'h0, 0, 32'h0);
    total++; if (obs_lat !== 0) begin bad++; $display("FAIL nonmem_latency got=%0d exp=0", obs_lat); end
    total++; if (o_lsu_alu_res !== 32'h1234) begin bad++; $display("FAIL nonmem_alu got=%h exp=00001234", o_lsu_alu_res); end
    total++; if (obs_req_cnt !== 0) begin bad++; $display("FAIL nonmem_req got=%0d exp=0", obs_req_cnt); end
    total++; if (o_lsu_gpr_rd_id !== 5'd7 || o_lsu_pc !== 32'h400 || o_lsu_ctr_reg_wr_en !== 1'b1) begin
      bad++; $display("FAIL nonmem_ctl got rd=%0d pc=%h wen=%b exp rd=7 pc=400 wen=1", o_lsu_gpr_rd_id, o_lsu_pc, o_lsu_ctr_reg_wr_en);
    end
    total++; if (o_lsu_ram_res !== 32'h0) begin bad++; $display("FAIL nonmem_ramres got=%h exp=0", o_lsu_ram_res); end
    accept(0);
    total++; if (o_lsu_ready !== 1'b1) begin bad++; $display("FAIL nonmem_back_idle got=%b exp=1", o_lsu_ready); end
  endtask

  task automatic test_load_1s();
    do_txn(32'h500, 1, REG_WR_SRC_MEM, 5'd3, RAM_BYT_1S, 0, 32'h1003, 32'h0, 3, 32'h80FF_FFFF);
    total++; if (o_lsu_ram_res !== 32'hFFFF_FF80) begin bad++; $display("FAIL load1s_data got=%h exp=ffffff80", o_lsu_ram_res); end
    total++; if (obs_addr !== 32'h1000) begin bad++; $display("FAIL load1s_addr got=%h exp=00001000", obs_addr); end
    total++; if (obs_lat !== 4) begin bad++; $display("FAIL load1s_latency got=%0d exp=4", obs_lat); end
    total++; if (obs_wr_en !== 1'b0) begin bad++; $display("FAIL load1s_wren got=%b exp=0", obs_wr_en); end
    accept(0);
  endtask

  task automatic test_store_half();
    do_txn(32'h600, 0, REG_WR_SRC_ALU, 5'd0, RAM_BYT_2U, 1, 32'h2002, 32'hABCD, 0, 32'h0);
    total++; if (obs_mask !== 4'b1100) begin bad++; $display("FAIL sth_mask got=%b exp=1100", obs_mask); end
    total++; if (obs_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sth_data got=%h exp=abcdabcd", obs_wdata); end
    total++; if (obs_addr !== 32'h2000 || obs_wr_en !== 1'b1) begin
      bad++; $display("FAIL sth_addr got addr=%h wen=%b exp addr=2000 wen=1", obs_addr, obs_wr_en);
    end
    total++; if (obs_lat !== 1) begin bad++; $display("FAIL sth_latency got=%0d exp=1", obs_lat); end
    total++; if (o_lsu_ram_res !== 32'h0) begin bad++; $display("FAIL sth_ramres got=%h exp=0", o_lsu_ram_res); end
    accept(0);
  endtask

  task automatic test_timeout();
    do_txn(32'h700, 1, REG_WR_SRC_MEM, 5'd9, RAM_BYT_4, 0, 32'h3000, 32'h0, 100000, 32'h0);
    total++; if (obs_req_cnt !== 255) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=255", obs_req_cnt); end
    total++; if (o_lsu_valid !== 1'b1 || o_lsu_err !== 1'b1) begin
      bad++; $display("FAIL tmo_err got valid=%b err=%b exp 1 1", o_lsu_valid, o_lsu_err);
    end
    total++; if (o_lsu_ctr_reg_wr_en !== 1'b0) begin bad++; $display("FAIL tmo_wen got=%b exp=0", o_lsu_ctr_reg_wr_en); end
    accept(2);
    total++; if (o_lsu_ready !== 1'b1) begin bad++; $display("FAIL tmo_back_idle got=%b exp=1", o_lsu_ready); end
  endtask

  task automatic test_ack_at_timeout();
    // ack arrives on the last allowed request cycle: a normal completion
    do_txn(32'h710, 1, REG_WR_SRC_MEM, 5'd9, RAM_BYT_2U, 0, 32'h3002, 32'h0, 254, 32'hBEEF_1234);
    total++; if (o_lsu_err !== 1'b0 || o_lsu_ram_res !== 32'h0000_BEEF || o_lsu_ctr_reg_wr_en !== 1'b1) begin
      bad++; $display("FAIL ack_tmo_same got err=%b res=%h wen=%b exp err=0 res=0000beef wen=1",
                      o_lsu_err, o_lsu_ram_res, o_lsu_ctr_reg_wr_en);
    end
    accept(0);
  endtask

  task automatic test_hold();
    logic [31:0] alu0;
    do_txn(32'h800, 1, REG_WR_SRC_MEM, 5'd4, RAM_BYT_2S, 0, 32'h4002, 32'h0, 1, 32'h8001_0000);
    alu0 = 32'h4002;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (o_lsu_valid !== 1'b1 || o_lsu_ready !== 1'b0 || o_lsu_alu_res !== alu0 ||
          o_lsu_ram_res !== 32'hFFFF_8001 || o_ram_req !== 1'b0) begin
        bad++; $display("FAIL hold_c%0d got v=%b rdy=%b alu=%h ram=%h req=%b exp v=1 rdy=0 alu=%h ram=ffff8001 req=0",
                        c, o_lsu_valid, o_lsu_ready, o_lsu_alu_res, o_lsu_ram_res, o_ram_req, alu0);
      end
      i_e2l_valid = 1;  // offered but must not be taken while holding
      @(negedge i_sys_clk);
    end
    i_e2l_valid = 0;
    accept(0);
    total++; if (o_lsu_ready !== 1'b1 || o_lsu_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got rdy=%b v=%b exp rdy=1 v=0", o_lsu_ready, o_lsu_valid);
    end
  endtask

  task automatic test_reset_in_req();
    i_e2l_valid = 1; i_e2l_ctr_reg_wr_src = REG_WR_SRC_MEM; i_e2l_ctr_ram_wr_en = 0;
    i_e2l_ctr_ram_byt = RAM_BYT_4; i_e2l_res = 32'h5000;
    @(negedge i_sys_clk);
    i_e2l_valid = 0;
    @(negedge i_sys_clk);
    total++; if (o_ram_req !== 1'b1) begin bad++; $display("FAIL rst_req_pre got=%b exp=1", o_ram_req); end
    i_sys_rst_n = 0;
    #1;
    total++; if (o_ram_req !== 1'b0) begin bad++; $display("FAIL rst_req_drop got=%b exp=0", o_ram_req); end
    @(negedge i_sys_clk);
    i_sys_rst_n = 1;
    @(negedge i_sys_clk);
    total++; if (o_lsu_ready !== 1'b1 || o_lsu_valid !== 1'b0 || o_lsu_alu_res !== 32'h0) begin
      bad++; $display("FAIL rst_after got rdy=%b v=%b alu=%h exp 1 0 0", o_lsu_ready, o_lsu_valid, o_lsu_alu_res);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          kind  = $urandom_range(0, 2);
      logic [2:0]  byt   = 3'($urandom_range(0, 4));
      logic [31:0] addr  = $urandom();
      logic [31:0] rs2   = $urandom();
      logic [31:0] word  = $urandom();
      int          dly   = $urandom_range(0, 6);
      logic        wen   = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      logic [2:0]  src   = (kind == 1) ? REG_WR_SRC_MEM : REG_WR_SRC_ALU;
      logic [31:0] got;
`ifdef LSU_MISALIGN_CHK_EN
      if (sz_of(byt) == 2) addr[0] = 1'b0;
      if (sz_of(byt) == 4) addr[1:0] = 2'b00;
`endif
      exp_q.push_back((kind == 1) ? model_load(byt, addr, word) : 32'h0);
      do_txn($urandom(), wen, src, 5'($urandom()), byt, kind == 2, addr, rs2, dly, word);
      got = exp_q.pop_front();
      total++; if (o_lsu_ram_res !== got) begin bad++; $display("FAIL rnd%0d_ramres got=%h exp=%h", n, o_lsu_ram_res, got); end
      total++; if (o_lsu_alu_res !== addr || o_lsu_ctr_reg_wr_en !== wen || o_lsu_err !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_ctl got alu=%h wen=%b err=%b exp alu=%h wen=%b err=0",
                        n, o_lsu_alu_res, o_lsu_ctr_reg_wr_en, o_lsu_err, addr, wen);
      end
      total++;
      if (kind == 0) begin
        if (obs_req_cnt !== 0 || obs_lat !== 0) begin
          bad++; $display("FAIL rnd%0d_nonmem got req=%0d lat=%0d exp 0 0", n, obs_req_cnt, obs_lat);
        end
      end else if (obs_req_cnt !== dly + 1 || obs_lat !== dly + 1 || obs_unstable !== 1'b0 ||
                   obs_addr !== {addr[31:2], 2'b00}) begin
        bad++; $display("FAIL rnd%0d_req got cnt=%0d lat=%0d unstable=%b addr=%h exp cnt=%0d lat=%0d unstable=0 addr=%h",
                        n, obs_req_cnt, obs_lat, obs_unstable, obs_addr, dly + 1, dly + 1, {addr[31:2], 2'b00});
      end
      if (kind == 2) begin
        total++;
        if (obs_mask !== model_mask(byt, addr) || obs_wdata !== model_wdata(byt, rs2) || obs_wr_en !== 1'b1) begin
          bad++; $display("FAIL rnd%0d_store got mask=%b data=%h wen=%b exp mask=%b data=%h wen=1",
                          n, obs_mask, obs_wdata, obs_wr_en, model_mask(byt, addr), model_wdata(byt, rs2));
        end
      end
      accept($urandom_range(0, 2));
    end
  endtask

`ifdef LSU_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_txn(32'h900, 1, REG_WR_SRC_MEM, 5'd2, RAM_BYT_4, 0, 32'h1001, 32'h0, 0, 32'h0);
    total++; if (obs_req_cnt !== 0 || obs_lat !== 0) begin
      bad++; $display("FAIL mis_noreq got req=%0d lat=%0d exp 0 0", obs_req_cnt, obs_lat);
    end
    total++; if (o_lsu_misalign !== 1'b1 || o_lsu_ctr_reg_wr_en !== 1'b0) begin
      bad++; $display("FAIL mis_flag got mis=%b wen=%b exp mis=1 wen=0", o_lsu_misalign, o_lsu_ctr_reg_wr_en);
    end
    accept(0);
    do_txn(32'h904, 1, REG_WR_SRC_MEM, 5'd2, RAM_BYT_2U, 0, 32'h1002, 32'h0, 0, 32'h1234_5678);
    total++; if (o_lsu_misalign !== 1'b0 || o_lsu_ram_res !== 32'h0000_1234) begin
      bad++; $display("FAIL mis_aligned got mis=%b res=%h exp mis=0 res=00001234", o_lsu_misalign, o_lsu_ram_res);
    end
    accept(0);
  endtask
`endif

  initial begin
    idle_inputs();
    i_sys_rst_n = 0;
    repeat (3) @(negedge i_sys_clk);
    i_sys_rst_n = 1;
    @(negedge i_sys_clk);
    test_reset();
    test_nonmem();
    test_load_1s();
    test_store_half();
    test_hold();
    test_timeout();
    test_ack_at_timeout();
    test_random();
`ifdef LSU_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_reset_in_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
